// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM state
// encoding, PC/writeback mux selects and fault cause codes.
package cpu_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Controller state, visible on the debug state port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  // Register-file writeback source select
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  // Sticky fault cause
  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_cause_e;

  // Opcodes the controller knows how to sequence
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Opcodes that need a data-memory phase
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_timeout.sv
// Memory wait-cycle counter. Counts cycles a request is outstanding without
// a handshake and flags the cycle in which the TIMEOUT-th wait occurs.
module mem_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Wait counter: cleared on handshake/idle, saturates at the last wait slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expiry is qualified by count, so a same-cycle mem_ready always wins
  assign expired = count && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: sequences fetch, decode, execute, memory
// and writeback, counts retired instructions and latches sticky faults.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  state_e     state_q;
  logic [6:0] op_q;
  logic       retire;
  logic       tmo_clear;
  logic       tmo_count;
  logic       tmo_expired;

  assign state = state_q;

  // Counter runs only while a request waits; any other cycle clears it
  assign tmo_count = mem_req && !mem_ready;
  assign tmo_clear = !mem_req || mem_ready;

  mem_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .count  (tmo_count),
    .expired(tmo_expired)
  );

  // Strobes decoded from registered state plus live handshake/compare inputs;
  // IDLE (including during reset) and FAULT fall through to all-zero defaults
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    pc_src       = PC_PLUS4;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXEC: begin
        if (op_q == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? PC_TARGET : PC_PLUS4;
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_STORE);
        if (mem_ready && (op_q == OP_STORE)) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (op_q == OP_LOAD) begin
          wb_sel = WB_MEM;
        end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
          wb_sel = WB_PC4;
        end
        if (op_q == OP_JAL) begin
          pc_src = PC_TARGET;
        end else if (op_q == OP_JALR) begin
          pc_src = PC_JALR;
        end
      end
      default: begin
      end
    endcase
  end

  // State sequencing, opcode latch, retire counter and sticky fault capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      instret     <= '0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      if (retire) begin
        instret <= instret + 32'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (tmo_expired) begin
            state_q     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= FC_TIMEOUT;
          end
        end
        ST_DECODE: begin
          op_q <= opcode;
          if (is_legal_op(opcode)) begin
            state_q <= ST_EXEC;
          end else begin
            state_q     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= FC_ILLEGAL;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_BRANCH) begin
            state_q <= run ? ST_FETCH : ST_IDLE;
          end else if (is_mem_op(op_q)) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LOAD) begin
              state_q <= ST_WB;
            end else begin
              state_q <= run ? ST_FETCH : ST_IDLE;
            end
          end else if (tmo_expired) begin
            state_q     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= FC_TIMEOUT;
          end
        end
        ST_WB: begin
          state_q <= run ? ST_FETCH : ST_IDLE;
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams with random memory latencies, scored against a
// per-instruction latency/strobe model.
module tb_multicycle_ctrl;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] ALUOP  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        fault;
  logic [1:0]  fault_cause;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] model_ret = '0;
  logic [6:0]  legal_ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ADDI, ALUOP};

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .pc_src(pc_src), .wb_sel(wb_sel), .state(state),
    .instret(instret), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Assert reset in a low-clock window, check the reset image, release and
  // leave the DUT in IDLE with run=1 so the next window is FETCH.
  task automatic start_from_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_fault", {30'd0, fault_cause}, 32'd0);
    chk("rst_strobes", 32'({fault, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we}), 32'd0);
    model_ret = '0;
    @(negedge clk);
    reset = 1'b0; run = 1'b1;
    #1;
    chk("idle_state", 32'(state), 32'd0);
  endtask

  // One instruction starting in FETCH; fd/md are the wait cycles before
  // mem_ready in the fetch and data phases.
  task automatic run_instr(input logic [6:0] op, input logic taken,
                           input int unsigned fd, input int unsigned md, input logic rn);
    int unsigned cyc = 0, phase = 0, wcnt = 0, n_ir = 0, ir_cyc = 0;
    int unsigned n_reg = 0, n_mwe = 0, n_req = 0, n_bad_addr = 0;
    int unsigned exp_cyc, exp_reg, exp_wb, exp_pcs, exp_mwe, exp_req;
    logic [1:0] pcs_got = '0, wbs_got = '0;
    logic done = 1'b0;
    bit is_ld, is_st, is_br, is_mem;
    is_ld = (op == LOAD); is_st = (op == STORE); is_br = (op == BRANCH);
    is_mem = is_ld || is_st;
    exp_cyc = (is_br ? 3 : (is_ld ? 5 : 4)) + fd + (is_mem ? md : 0);
    exp_reg = (is_br || is_st) ? 0 : 1;
    exp_wb  = is_ld ? 1 : ((op == JAL || op == JALR) ? 2 : 0);
    exp_pcs = is_br ? (taken ? 1 : 0) : (op == JAL ? 1 : (op == JALR ? 2 : 0));
    exp_mwe = is_st ? md + 1 : 0;
    exp_req = fd + 1 + (is_mem ? md + 1 : 0);
    while (!done && cyc < 40) begin
      @(negedge clk);
      opcode = op; branch_taken = taken; run = rn; mem_ready = 1'b0;
      #1;
      cyc++;
      if (mem_req) begin
        n_req++;
        if (mem_addr_sel !== logic'(phase == 1)) n_bad_addr++;
        mem_ready = (wcnt == ((phase == 0) ? fd : md));
        if (mem_ready) begin phase++; wcnt = 0; end
        else wcnt++;
      end
      #1;
      if (ir_we) begin n_ir++; ir_cyc = cyc; end
      if (mem_we) n_mwe++;
      if (reg_we) begin n_reg++; wbs_got = wb_sel; end
      if (pc_we) begin pcs_got = pc_src; done = 1'b1; end
    end
    chk("retired_in_budget", 32'(done), 32'd1);
    chk("latency", cyc, exp_cyc);
    chk("ir_we_count", n_ir, 32'd1);
    chk("ir_we_cycle", ir_cyc, fd + 1);
    chk("reg_we_count", n_reg, exp_reg);
    if (exp_reg != 0) chk("wb_sel", 32'(wbs_got), exp_wb);
    chk("pc_src", 32'(pcs_got), exp_pcs);
    chk("mem_we_cycles", n_mwe, exp_mwe);
    chk("mem_req_cycles", n_req, exp_req);
    chk("addr_sel_bad", n_bad_addr, 32'd0);
    model_ret = model_ret + 32'd1;
    @(posedge clk);
    #1;
    chk("instret", instret, model_ret);
    chk("post_state", 32'(state), rn ? 32'd1 : 32'd0);
    chk("no_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    int unsigned cnt;

    // Basic ALU op, zero-wait memory
    start_from_reset();
    run_instr(ADDI, 1'b0, 0, 0, 1'b1);
    // LOAD with 3-cycle data-phase delay: 8 cycles, 4 stable request cycles
    run_instr(LOAD, 1'b0, 0, 3, 1'b1);
    // Branch taken then not taken
    run_instr(BRANCH, 1'b1, 0, 0, 1'b1);
    run_instr(BRANCH, 1'b0, 0, 0, 1'b1);
    run_instr(STORE, 1'b0, 1, 2, 1'b1);
    run_instr(JAL, 1'b0, 0, 0, 1'b1);
    run_instr(JALR, 1'b0, 0, 0, 1'b1);

    // Randomized instruction stream with random memory latencies
    for (int i = 0; i < 40; i++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    // run dropped during an instruction: it completes, then controller idles
    run_instr(ALUOP, 1'b0, 2, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("idle_hold", 32'(state), 32'd0);
    chk("idle_no_req", 32'(mem_req), 32'd0);
    run = 1'b1;
    run_instr(LUI, 1'b0, 0, 0, 1'b1);

    // Illegal opcode: fault after DECODE, no further requests
    start_from_reset();
    @(negedge clk);
    opcode = 7'b1111111; mem_ready = 1'b1;
    #1;
    chk("ill_ir_we", 32'(ir_we), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("ill_decode", 32'(state), 32'd2);
    @(posedge clk);
    #1;
    chk("ill_state", 32'(state), 32'd6);
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_cause", 32'(fault_cause), 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b1;
      #1;
      if (mem_req || ir_we || pc_we || reg_we) cnt++;
    end
    chk("ill_no_strobes", cnt, 32'd0);
    chk("ill_held", 32'(state), 32'd6);
    chk("ill_instret", instret, 32'd0);

    // Fetch timeout: TIMEOUT=4 waits without mem_ready
    start_from_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("tmo_wait_state", 32'(state), 32'd1);
      chk("tmo_wait_req", 32'({mem_req, mem_addr_sel, mem_we, fault}), 32'b1000);
    end
    @(posedge clk);
    #1;
    chk("tmo_state", 32'(state), 32'd6);
    chk("tmo_cause", 32'(fault_cause), 32'd2);
    chk("tmo_req_drop", 32'(mem_req), 32'd0);

    // mem_ready arriving in the 4th wait cycle wins over the timeout
    start_from_reset();
    run_instr(ADDI, 1'b0, 3, 0, 1'b1);
    run_instr(STORE, 1'b0, 3, 3, 1'b1);

    // Data-phase timeout
    start_from_reset();
    @(negedge clk); opcode = LOAD; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("mtmo_wait", 32'({state, mem_req, mem_addr_sel}), 32'b10011);
    end
    @(posedge clk);
    #1;
    chk("mtmo_state", 32'(state), 32'd6);
    chk("mtmo_cause", 32'(fault_cause), 32'd2);

    // Reset while a data-phase request is pending
    start_from_reset();
    run_instr(ADDI, 1'b0, 0, 0, 1'b1);
    @(negedge clk); opcode = LOAD; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pend_state", 32'({state, mem_req}), 32'b1001);
    #1;
    reset = 1'b1;
    #1;
    chk("async_strobes", 32'({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we}), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_instret", instret, 32'd0);
    chk("async_fault", 32'({fault, fault_cause}), 32'd0);
    model_ret = '0;
    @(negedge clk);
    reset = 1'b0; run = 1'b1;
    run_instr(ADDI, 1'b0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
